int_iq1_issue_queue: RTL and testbench
======================================

# int_iq1_issue_queue

Eight-entry integer issue queue (IQ1) that consumes free slot identifiers from the IQ1 free-slot circular queue. It writes dispatched micro-ops into those slots and tracks source-operand readiness through wakeup broadcasts. Each cycle it selects one ready entry, moves it into a registered issue stage for the integer execute port, and returns the vacated slot identifier to the free-slot queue.

## Interface
- IQDEEP, 8, number of entries.
- SLOTW, 5, slot identifier width; identifiers are 0,4,…,28, entry index = slot[4:2].
- PREGW, 7, physical register tag width.
- PAYW, 32, opaque micro-op payload width.

Ports:
- Clk  in  1  single clock.
- Rest  in  1  reset, asynchronous, active-low.
- DispValid  in  1  dispatch request.
- DispReady  out  1  dispatch accept.
- DispSrc1Tag / DispSrc2Tag  in  PREGW  source tags.
- DispSrc1Rdy / DispSrc2Rdy  in  1  source already available.
- DispDstTag  in  PREGW  destination tag.
- DispPayload  in  PAYW  micro-op payload.
- FreeSlot  in  SLOTW  head of free-slot queue (its PreOut).
- FreeEmpty  in  1  free-slot queue empty.
- FreeRable  out  1  pop free-slot queue.
- RetSlotValid  out  1  push returned slot (free-slot queue Wable).
- RetSlot  out  SLOTW  returned slot identifier.
- WkValid0 / WkValid1  in  1  wakeup broadcast valid.
- WkTag0 / WkTag1  in  PREGW  wakeup tags.
- IssueValid  out  1  issue stage holds a micro-op.
- IssueReady  in  1  execute accepts.
- IssueSrc1Tag / IssueSrc2Tag / IssueDstTag  out  PREGW  issued tags.
- IssuePayload  out  PAYW  issued payload.
- IssueSlot  out  SLOTW  slot the micro-op occupied.
- Flush  in  1  pipeline flush; the same signal drives the free-slot queue clean input externally.
- Occupancy  out  4  valid entries in the array, 0–8.

## Operation
- Per entry: Valid, Src1Tag/Rdy, Src2Tag/Rdy, DstTag, Payload.
- DispReady = !FreeEmpty && !Flush, combinational.
- FreeRable = DispValid && DispReady.
- On accept, the entry at FreeSlot[4:2] is written and Valid is set.
- A dispatch into a slot whose entry is already Valid is a protocol error; the bench asserts it never occurs.
- Wakeup: any valid entry source with a tag equal to an asserted WkTagN sets its Rdy.
- Dispatch-cycle bypass: a dispatching source whose tag matches an asserted WkTagN in the same cycle is written with Rdy=1.
- An entry is eligible when Valid && Src1Rdy && Src2Rdy.
- Select picks one eligible entry per cycle.
- The issue register loads when (!IssueValid || IssueReady) and an entry is eligible. On load:
  - the selected entry's Valid clears;
  - RetSlotValid=1 and RetSlot=its slot are registered for exactly one cycle, aligned with the new IssueValid.
- When IssueReady=1 and nothing is eligible, IssueValid drops to 0 at the next edge.
- Flush (synchronous, highest priority):
  - clears all Valid bits, IssueValid, RetSlotValid and Occupancy next cycle;
  - accepts no dispatch and returns no slots.
- Occupancy updates at each edge: +1 on dispatch, −1 on issue load; both in one cycle leaves it unchanged.
- Reset values: IssueValid, IssueSrc*/Dst tags, IssuePayload, IssueSlot, RetSlotValid, RetSlot and Occupancy are 0; all Valid bits are 0. DispReady and FreeRable follow their combinational equations.

## Timing
- Dispatch in cycle t: FreeRable in t, entry visible in t+1.
- Issue: earliest IssueValid in t+2 for a dispatch in cycle t with both sources ready.
- Wakeup in cycle t: the entry is eligible in t+1.
- Backpressure: while IssueValid && !IssueReady, all Issue* outputs hold stable and no entry leaves the array.
- Reset asserted mid-operation clears state asynchronously; outputs reach reset values immediately.

## Configuration
- INTIQ1_AGE_SELECT_EN defined: oldest-first select via an 8×8 age matrix, updated on dispatch (new entry is younger than all valid entries).
- Undefined: the eligible entry with the lowest index wins; the age matrix is not built.

## Structure
- Shared package int_iq1_pkg holds:
  - IQDEEP, SLOTW, PREGW, PAYW constants;
  - the entry typedef;
  - the slot-to-index conversion function.
- Sub-module int_iq1_age_matrix covers age tracking and the oldest-eligible one-hot output; it is instantiated only under INTIQ1_AGE_SELECT_EN.

## Test plan
- Reset release, dispatch both-ready micro-op with FreeSlot=0 at cycle t -> FreeRable=1 at t; IssueValid=1 and RetSlotValid=1 with RetSlot=0, IssueSlot=0 at t+2.
- Dispatch slot 4 then slot 8, each with Src1Tag=10 not ready; WkValid0=1, WkTag0=10 at cycle t, IssueReady=1 -> slot 4 issues at t+2, slot 8 at t+3 (age-select build; lowest-index build gives the same order here).
- Dispatch with DispSrc2Tag=33 unready while WkValid1=1, WkTag1=33 in the same cycle -> entry issues two cycles later with no further wakeup.
- Hold IssueReady=0 for 3 cycles with 2 eligible entries -> IssuePayload unchanged; Occupancy stays 2; no RetSlotValid; after release, the next entry issues one cycle later.
- FreeEmpty=1 with DispValid=1 -> DispReady=0, FreeRable=0, Occupancy unchanged.
- Three valid entries plus IssueValid=1, Flush=1 for one cycle -> next cycle IssueValid=0, Occupancy=0, RetSlotValid=0; DispReady=0 during the Flush cycle.

Source files
------------

// File: rtl/int_iq1_pkg.sv
// rtl/int_iq1_pkg.sv - shared constants, entry type and slot helpers for IQ1
//
// Purpose : common definitions imported by the IQ1 issue queue and its age matrix.
// Contents: IQDEEP/SLOTW/PREGW/PAYW/IDXW constants, iq_entry_t, slot<->index helpers.
// Config  : none (INTIQ1_AGE_SELECT_EN is consumed by int_iq1_issue_queue).
package int_iq1_pkg;

    localparam int IQDEEP = 8;
    localparam int SLOTW  = 5;
    localparam int PREGW  = 7;
    localparam int PAYW   = 32;
    localparam int IDXW   = 3;

    typedef struct packed {
        logic             valid;
        logic [PREGW-1:0] src1_tag;
        logic             src1_rdy;
        logic [PREGW-1:0] src2_tag;
        logic             src2_rdy;
        logic [PREGW-1:0] dst_tag;
        logic [PAYW-1:0]  payload;
    } iq_entry_t;

    // Slot identifiers are multiples of four; the entry index is slot / 4.
    function automatic logic [IDXW-1:0] slot_to_idx(input logic [SLOTW-1:0] slot);
        return IDXW'(slot >> 2);
    endfunction

    function automatic logic [SLOTW-1:0] idx_to_slot(input logic [IDXW-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/int_iq1_age_matrix.sv
// rtl/int_iq1_age_matrix.sv - age tracking and oldest-eligible one-hot select for IQ1
//
// Purpose : remembers relative dispatch order of the entries and picks the oldest
//           eligible one. Only instantiated when INTIQ1_AGE_SELECT_EN is defined.
// Ports   : clk_i, rst_ni       - clock, asynchronous active-low reset
//           disp_en_i           - an entry is being written this cycle
//           disp_idx_i          - index of the entry being written
//           eligible_i          - per-entry eligibility (valid and both sources ready)
//           oldest_o            - one-hot of the oldest eligible entry (zero if none)
module int_iq1_age_matrix
    import int_iq1_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              disp_en_i,
    input  logic [IDXW-1:0]   disp_idx_i,
    input  logic [IQDEEP-1:0] eligible_i,
    output logic [IQDEEP-1:0] oldest_o
);

    // age_q[i][j] = 1 means entry i is older than entry j.
    logic [IQDEEP-1:0][IQDEEP-1:0] age_q;
    logic [IQDEEP-1:0][IQDEEP-1:0] age_d;

    // A newly written entry becomes younger than every other entry: its row is
    // cleared and its column is set. Stale bits of invalid entries are harmless
    // because they are rewritten on that entry's next dispatch.
    always_comb begin
        age_d = age_q;
        if (disp_en_i) begin
            for (int j = 0; j < IQDEEP; j++) begin
                age_d[disp_idx_i][j] = 1'b0;
                if (IDXW'(j) != disp_idx_i) begin
                    age_d[j][disp_idx_i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        for (int i = 0; i < IQDEEP; i++) begin
            oldest_o[i] = eligible_i[i];
            for (int j = 0; j < IQDEEP; j++) begin
                if ((j != i) && eligible_i[j] && age_q[j][i]) begin
                    oldest_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/int_iq1_issue_queue.sv
// rtl/int_iq1_issue_queue.sv - eight-entry integer issue queue with registered issue stage
//
// Purpose : writes dispatched micro-ops into slots taken from the free-slot queue,
//           tracks source readiness via two wakeup broadcasts, selects one eligible
//           entry per cycle into a registered issue stage and returns its slot.
// Config  : INTIQ1_AGE_SELECT_EN defined -> oldest-first select (int_iq1_age_matrix);
//           undefined -> lowest eligible index wins.
// Ports   : clk_i, rst_ni                      - clock, asynchronous active-low reset
//           disp_*                             - dispatch request/accept and micro-op fields
//           free_slot_i, free_empty_i, free_rable_o - free-slot queue head / empty / pop
//           ret_slot_valid_o, ret_slot_o       - slot returned to the free-slot queue
//           wk_valid0/1_i, wk_tag0/1_i         - wakeup broadcasts
//           issue_*                            - registered issue stage toward execute
//           flush_i                            - synchronous pipeline flush
//           occupancy_o                        - number of valid entries, 0..8
module int_iq1_issue_queue
    import int_iq1_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [PREGW-1:0] disp_src1_tag_i,
    input  logic [PREGW-1:0] disp_src2_tag_i,
    input  logic             disp_src1_rdy_i,
    input  logic             disp_src2_rdy_i,
    input  logic [PREGW-1:0] disp_dst_tag_i,
    input  logic [PAYW-1:0]  disp_payload_i,
    input  logic [SLOTW-1:0] free_slot_i,
    input  logic             free_empty_i,
    output logic             free_rable_o,
    output logic             ret_slot_valid_o,
    output logic [SLOTW-1:0] ret_slot_o,
    input  logic             wk_valid0_i,
    input  logic             wk_valid1_i,
    input  logic [PREGW-1:0] wk_tag0_i,
    input  logic [PREGW-1:0] wk_tag1_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [PREGW-1:0] issue_src1_tag_o,
    output logic [PREGW-1:0] issue_src2_tag_o,
    output logic [PREGW-1:0] issue_dst_tag_o,
    output logic [PAYW-1:0]  issue_payload_o,
    output logic [SLOTW-1:0] issue_slot_o,
    input  logic             flush_i,
    output logic [3:0]       occupancy_o
);

    function automatic logic tag_hit(
        input logic [PREGW-1:0] tag,
        input logic             v0,
        input logic [PREGW-1:0] t0,
        input logic             v1,
        input logic [PREGW-1:0] t1
    );
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    iq_entry_t ent_q [IQDEEP];
    iq_entry_t ent_d [IQDEEP];

    logic             issue_valid_q, issue_valid_d;
    logic [PREGW-1:0] issue_src1_tag_q, issue_src1_tag_d;
    logic [PREGW-1:0] issue_src2_tag_q, issue_src2_tag_d;
    logic [PREGW-1:0] issue_dst_tag_q, issue_dst_tag_d;
    logic [PAYW-1:0]  issue_payload_q, issue_payload_d;
    logic [SLOTW-1:0] issue_slot_q, issue_slot_d;
    logic             ret_slot_valid_q, ret_slot_valid_d;
    logic [SLOTW-1:0] ret_slot_q, ret_slot_d;
    logic [3:0]       occupancy_q, occupancy_d;

    logic              disp_fire;
    logic [IDXW-1:0]   disp_idx;
    logic [IQDEEP-1:0] elig;
    logic [IQDEEP-1:0] sel_oh;
    logic [IDXW-1:0]   sel_idx;
    logic              issue_load;

    // Dispatch handshake is purely combinational so the free-slot pop lands
    // in the same cycle as the accept.
    assign disp_ready_o = !free_empty_i && !flush_i;
    assign free_rable_o = disp_valid_i && disp_ready_o;
    assign disp_fire    = free_rable_o;
    assign disp_idx     = slot_to_idx(free_slot_i);

    always_comb begin
        for (int i = 0; i < IQDEEP; i++) begin
            elig[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
        end
    end

`ifdef INTIQ1_AGE_SELECT_EN
    int_iq1_age_matrix u_age_matrix (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .disp_en_i  (disp_fire),
        .disp_idx_i (disp_idx),
        .eligible_i (elig),
        .oldest_o   (sel_oh)
    );
`else
    // Isolate the lowest set bit.
    assign sel_oh = elig & (~elig + IQDEEP'(1));
`endif

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < IQDEEP; i++) begin
            if (sel_oh[i]) begin
                sel_idx = sel_idx | IDXW'(i);
            end
        end
    end

    // The issue stage only advances when it is empty or being drained.
    assign issue_load = !flush_i && (|elig) && (!issue_valid_q || issue_ready_i);

    always_comb begin
        for (int i = 0; i < IQDEEP; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                if (tag_hit(ent_q[i].src1_tag, wk_valid0_i, wk_tag0_i, wk_valid1_i, wk_tag1_i)) begin
                    ent_d[i].src1_rdy = 1'b1;
                end
                if (tag_hit(ent_q[i].src2_tag, wk_valid0_i, wk_tag0_i, wk_valid1_i, wk_tag1_i)) begin
                    ent_d[i].src2_rdy = 1'b1;
                end
            end
            if (issue_load && sel_oh[i]) begin
                ent_d[i].valid = 1'b0;
            end
            // Same-cycle wakeup is bypassed into the freshly written sources.
            if (disp_fire && (disp_idx == IDXW'(i))) begin
                ent_d[i].valid    = 1'b1;
                ent_d[i].src1_tag = disp_src1_tag_i;
                ent_d[i].src2_tag = disp_src2_tag_i;
                ent_d[i].dst_tag  = disp_dst_tag_i;
                ent_d[i].payload  = disp_payload_i;
                ent_d[i].src1_rdy = disp_src1_rdy_i ||
                    tag_hit(disp_src1_tag_i, wk_valid0_i, wk_tag0_i, wk_valid1_i, wk_tag1_i);
                ent_d[i].src2_rdy = disp_src2_rdy_i ||
                    tag_hit(disp_src2_tag_i, wk_valid0_i, wk_tag0_i, wk_valid1_i, wk_tag1_i);
            end
            if (flush_i) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        issue_valid_d    = issue_valid_q;
        issue_src1_tag_d = issue_src1_tag_q;
        issue_src2_tag_d = issue_src2_tag_q;
        issue_dst_tag_d  = issue_dst_tag_q;
        issue_payload_d  = issue_payload_q;
        issue_slot_d     = issue_slot_q;
        ret_slot_valid_d = 1'b0;
        ret_slot_d       = ret_slot_q;
        if (flush_i) begin
            issue_valid_d = 1'b0;
        end else if (issue_load) begin
            issue_valid_d    = 1'b1;
            issue_src1_tag_d = ent_q[sel_idx].src1_tag;
            issue_src2_tag_d = ent_q[sel_idx].src2_tag;
            issue_dst_tag_d  = ent_q[sel_idx].dst_tag;
            issue_payload_d  = ent_q[sel_idx].payload;
            issue_slot_d     = idx_to_slot(sel_idx);
            ret_slot_valid_d = 1'b1;
            ret_slot_d       = idx_to_slot(sel_idx);
        end else if (issue_ready_i) begin
            issue_valid_d = 1'b0;
        end
    end

    always_comb begin
        if (flush_i) begin
            occupancy_d = '0;
        end else begin
            occupancy_d = occupancy_q + {3'b000, disp_fire} - {3'b000, issue_load};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IQDEEP; i++) begin
                ent_q[i] <= '0;
            end
            issue_valid_q    <= 1'b0;
            issue_src1_tag_q <= '0;
            issue_src2_tag_q <= '0;
            issue_dst_tag_q  <= '0;
            issue_payload_q  <= '0;
            issue_slot_q     <= '0;
            ret_slot_valid_q <= 1'b0;
            ret_slot_q       <= '0;
            occupancy_q      <= '0;
        end else begin
            for (int i = 0; i < IQDEEP; i++) begin
                ent_q[i] <= ent_d[i];
            end
            issue_valid_q    <= issue_valid_d;
            issue_src1_tag_q <= issue_src1_tag_d;
            issue_src2_tag_q <= issue_src2_tag_d;
            issue_dst_tag_q  <= issue_dst_tag_d;
            issue_payload_q  <= issue_payload_d;
            issue_slot_q     <= issue_slot_d;
            ret_slot_valid_q <= ret_slot_valid_d;
            ret_slot_q       <= ret_slot_d;
            occupancy_q      <= occupancy_d;
        end
    end

    assign issue_valid_o    = issue_valid_q;
    assign issue_src1_tag_o = issue_src1_tag_q;
    assign issue_src2_tag_o = issue_src2_tag_q;
    assign issue_dst_tag_o  = issue_dst_tag_q;
    assign issue_payload_o  = issue_payload_q;
    assign issue_slot_o     = issue_slot_q;
    assign ret_slot_valid_o = ret_slot_valid_q;
    assign ret_slot_o       = ret_slot_q;
    assign occupancy_o      = occupancy_q;

endmodule

// File: tb/tb_int_iq1_issue_queue.sv
// tb/tb_int_iq1_issue_queue.sv - randomized scoreboard bench for int_iq1_issue_queue
module tb_int_iq1_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [6:0]  s1_tag = '0, s2_tag = '0, dst_tag = '0;
    logic        s1_rdy = 1'b0, s2_rdy = 1'b0;
    logic [31:0] payload = '0;
    logic [4:0]  free_slot = '0;
    logic        free_empty = 1'b0;
    logic        free_rable;
    logic        ret_valid;
    logic [4:0]  ret_slot;
    logic        wkv0 = 1'b0, wkv1 = 1'b0;
    logic [6:0]  wkt0 = '0, wkt1 = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [6:0]  i_s1, i_s2, i_dst;
    logic [31:0] i_pay;
    logic [4:0]  i_slot;
    logic        flush = 1'b0;
    logic [3:0]  occupancy;

    always #5 clk = ~clk;

    int_iq1_issue_queue dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .disp_valid_i     (disp_valid),
        .disp_ready_o     (disp_ready),
        .disp_src1_tag_i  (s1_tag),
        .disp_src2_tag_i  (s2_tag),
        .disp_src1_rdy_i  (s1_rdy),
        .disp_src2_rdy_i  (s2_rdy),
        .disp_dst_tag_i   (dst_tag),
        .disp_payload_i   (payload),
        .free_slot_i      (free_slot),
        .free_empty_i     (free_empty),
        .free_rable_o     (free_rable),
        .ret_slot_valid_o (ret_valid),
        .ret_slot_o       (ret_slot),
        .wk_valid0_i      (wkv0),
        .wk_valid1_i      (wkv1),
        .wk_tag0_i        (wkt0),
        .wk_tag1_i        (wkt1),
        .issue_valid_o    (issue_valid),
        .issue_ready_i    (issue_ready),
        .issue_src1_tag_o (i_s1),
        .issue_src2_tag_o (i_s2),
        .issue_dst_tag_o  (i_dst),
        .issue_payload_o  (i_pay),
        .issue_slot_o     (i_slot),
        .flush_i          (flush),
        .occupancy_o      (occupancy)
    );

    typedef struct {
        logic [6:0]  s1, s2, dst;
        logic [31:0] pay;
        logic [4:0]  slot;
    } uop_t;

    // Reference model: a set of waiting micro-ops, an issue stage, a pending
    // slot return and the external free-slot list.
    bit   m_valid [8];
    bit   m_r1 [8], m_r2 [8];
    uop_t m_uop [8];
    int   m_seq [8];
    int   seq_ctr = 0;
    bit   m_iv = 0;
    uop_t m_stage;
    bit   m_rv = 0;
    int   m_rslot = 0;
    int   fq[$];
    uop_t sbq[$];

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void reset_free_list();
        fq = {};
        for (int i = 0; i < 8; i++) fq.push_back(i * 4);
    endfunction

    function automatic int count_valid();
        int c = 0;
        for (int i = 0; i < 8; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic bit woken(logic [6:0] tag);
        return (wkv0 && wkt0 == tag) || (wkv1 && wkt1 == tag);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        bit acc;
        bit load;
        int best = -1;
        int slot, idx;
        acc = disp_valid && !free_empty && !flush;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef INTIQ1_AGE_SELECT_EN
                if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        load = !flush && best >= 0 && (!m_iv || issue_ready);
        if (flush) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            m_iv = 0;
            m_rv = 0;
            reset_free_list();
            return;
        end
        if (m_rv) fq.push_back(m_rslot);
        if (load) begin
            m_valid[best] = 0;
            m_stage = m_uop[best];
            sbq.push_back(m_uop[best]);
            m_iv = 1;
            m_rv = 1;
            m_rslot = best * 4;
        end else begin
            m_rv = 0;
            if (issue_ready) m_iv = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i]) begin
                if (woken(m_uop[i].s1)) m_r1[i] = 1;
                if (woken(m_uop[i].s2)) m_r2[i] = 1;
            end
        end
        if (acc) begin
            slot = fq.pop_front();
            idx = slot / 4;
            check("dispatch_into_free_entry", m_valid[idx], 0);
            m_valid[idx] = 1;
            m_uop[idx].s1 = s1_tag;
            m_uop[idx].s2 = s2_tag;
            m_uop[idx].dst = dst_tag;
            m_uop[idx].pay = payload;
            m_uop[idx].slot = 5'(slot);
            m_r1[idx] = s1_rdy || woken(s1_tag);
            m_r2[idx] = s2_rdy || woken(s2_tag);
            m_seq[idx] = seq_ctr++;
        end
    endfunction

    // Monitor: compares the DUT against the model after every edge and pops
    // the scoreboard whenever a slot return marks a fresh issue.
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            check("issue_valid", issue_valid, m_iv);
            check("ret_slot_valid", ret_valid, m_rv);
            check("occupancy", occupancy, count_valid());
            if (m_iv) begin
                check("hold_payload", i_pay, m_stage.pay);
                check("hold_slot", i_slot, m_stage.slot);
            end
            if (ret_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    uop_t e;
                    e = sbq.pop_front();
                    check("issue_payload", i_pay, e.pay);
                    check("issue_src1_tag", i_s1, e.s1);
                    check("issue_src2_tag", i_s2, e.s2);
                    check("issue_dst_tag", i_dst, e.dst);
                    check("issue_slot", i_slot, e.slot);
                    check("ret_slot", ret_slot, e.slot);
                end
            end
        end
    end

    task automatic drive_cycle(input bit directed, input int cyc, inout int bp_mode, input bit idle);
        bit force_empty;
        @(negedge clk);
        if (cyc % 16 == 0) bp_mode = $urandom_range(0, 3);
        flush       = !directed && !idle && ($urandom_range(0, 99) < 2);
        force_empty = !directed && !idle && ($urandom_range(0, 99) < 5);
        free_empty  = force_empty || (fq.size() == 0);
        free_slot   = (fq.size() != 0) ? 5'(fq[0]) : 5'($urandom_range(0, 7) * 4);
        disp_valid  = directed || (!idle && ($urandom_range(0, 99) < 60));
        s1_tag      = 7'($urandom_range(0, 15));
        s2_tag      = 7'($urandom_range(0, 15));
        dst_tag     = 7'($urandom_range(0, 127));
        s1_rdy      = directed || ($urandom_range(0, 1) == 1);
        s2_rdy      = directed || ($urandom_range(0, 1) == 1);
        payload     = $urandom;
        wkv0        = !directed && ($urandom_range(0, 99) < 30);
        wkv1        = !directed && ($urandom_range(0, 99) < 30);
        wkt0        = 7'($urandom_range(0, 15));
        wkt1        = 7'($urandom_range(0, 15));
        issue_ready = directed || idle || (bp_mode != 0 && $urandom_range(0, 99) < 80);
        #1;
        check("disp_ready", disp_ready, !free_empty && !flush);
        check("free_rable", free_rable, disp_valid && !free_empty && !flush);
        n_vec++;
        model_step();
    endtask

    initial begin
        int bp_mode = 1;
        reset_free_list();
        repeat (3) @(posedge clk);
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_issue_payload", i_pay, 0);
        check("rst_issue_slot", i_slot, 0);
        check("rst_ret_slot", ret_slot, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1;
        drive_cycle(1, 1, bp_mode, 0);
        for (int c = 1; c < 3000; c++) drive_cycle(0, c, bp_mode, 0);
        for (int c = 0; c < 60; c++) drive_cycle(0, 1, bp_mode, 1);
        @(negedge clk);
        disp_valid = 1'b0;
        flush = 1'b0;
        wkv0 = 1'b0;
        wkv1 = 1'b0;
        mon_on = 0;
        check("scoreboard_drained", sbq.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_issue_valid", issue_valid, 0);
        check("async_rst_occupancy", occupancy, 0);
        check("async_rst_ret_valid", ret_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
